// File: rtl/adbg_jtag_tap.sv
// adbg_jtag_tap: IEEE 1149.1 TAP controller in front of the debug interface.
// Holds the TAP FSM, instruction register, IDCODE and BYPASS data registers,
// decodes the TAP-state strobes for the debug top level and muxes its TDO.
// Optional 32-bit user data register enabled by defining ADBG_TAP_USER_REG_EN.
module adbg_jtag_tap #(
  parameter int                  IR_WIDTH     = 4,
  parameter logic [31:0]         IDCODE_VALUE = 32'h249511C3,
  parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'h2,
  parameter logic [IR_WIDTH-1:0] DEBUG_INSTR  = 4'h8,
  parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = 4'hF
`ifdef ADBG_TAP_USER_REG_EN
  ,
  parameter logic [IR_WIDTH-1:0] USER_INSTR   = 4'h9
`endif
) (
  input  logic        tck_i,
  input  logic        trstn_i,
  input  logic        tms_i,
  input  logic        tdi_i,
  output logic        tdo_o,
  output logic        tdo_oe_o,
  output logic        test_logic_reset_o,
  output logic        shift_dr_o,
  output logic        pause_dr_o,
  output logic        update_dr_o,
  output logic        capture_dr_o,
  output logic        debug_select_o,
  input  logic        dbg_tdo_i
`ifdef ADBG_TAP_USER_REG_EN
  ,
  output logic [31:0] user_reg_o
`endif
);

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_e;

  tap_state_e          state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_latch;
  logic [31:0]         idcode_shift;
  logic                bypass_reg;
  logic                tdo_mux;
  logic                idcode_sel;
  logic                debug_sel;
  logic                user_sel;
  logic                bypass_sel;

  // TAP FSM: 1149.1 transitions on rising TCK, sampled TMS
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      state <= TEST_LOGIC_RESET;
    end else begin
      case (state)
        TEST_LOGIC_RESET: state <= tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state <= tms_i ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:        state <= tms_i ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       state <= tms_i ? EXIT1_DR  : SHIFT_DR;
        SHIFT_DR:         state <= tms_i ? EXIT1_DR  : SHIFT_DR;
        EXIT1_DR:         state <= tms_i ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         state <= tms_i ? EXIT2_DR  : PAUSE_DR;
        EXIT2_DR:         state <= tms_i ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        state <= tms_i ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:        state <= tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state <= tms_i ? EXIT1_IR  : SHIFT_IR;
        SHIFT_IR:         state <= tms_i ? EXIT1_IR  : SHIFT_IR;
        EXIT1_IR:         state <= tms_i ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         state <= tms_i ? EXIT2_IR  : PAUSE_IR;
        EXIT2_IR:         state <= tms_i ? UPDATE_IR : SHIFT_IR;
        UPDATE_IR:        state <= tms_i ? SELECT_DR : RUN_TEST_IDLE;
        default:          state <= TEST_LOGIC_RESET;
      endcase
    end
  end

  // State strobes are plain decodes so the debug top level sees them this cycle
  assign test_logic_reset_o = (state == TEST_LOGIC_RESET);
  assign shift_dr_o         = (state == SHIFT_DR);
  assign pause_dr_o         = (state == PAUSE_DR);
  assign update_dr_o        = (state == UPDATE_DR);
  assign capture_dr_o       = (state == CAPTURE_DR);

  // Instruction register: capture/shift path and the update latch
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      ir_shift <= '0;
      ir_latch <= IDCODE_INSTR;
    end else begin
      if (state == CAPTURE_IR)
        ir_shift <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
      else if (state == SHIFT_IR)
        ir_shift <= {tdi_i, ir_shift[IR_WIDTH-1:1]};
      if (state == TEST_LOGIC_RESET)
        ir_latch <= IDCODE_INSTR;
      else if (state == UPDATE_IR)
        ir_latch <= ir_shift;
    end
  end

  assign idcode_sel     = (ir_latch == IDCODE_INSTR);
  assign debug_sel      = (ir_latch == DEBUG_INSTR);
`ifdef ADBG_TAP_USER_REG_EN
  assign user_sel       = (ir_latch == USER_INSTR);
`else
  assign user_sel       = 1'b0;
`endif
  // Any opcode without its own register falls back to BYPASS
  assign bypass_sel     = (ir_latch == BYPASS_INSTR) || !(idcode_sel || debug_sel || user_sel);
  assign debug_select_o = debug_sel;

  // IDCODE and BYPASS data registers
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      idcode_shift <= '0;
      bypass_reg   <= 1'b0;
    end else begin
      if (idcode_sel && state == CAPTURE_DR)
        idcode_shift <= IDCODE_VALUE;
      else if (idcode_sel && state == SHIFT_DR)
        idcode_shift <= {tdi_i, idcode_shift[31:1]};
      if (state == CAPTURE_DR)
        bypass_reg <= 1'b0;
      else if (state == SHIFT_DR)
        bypass_reg <= tdi_i;
    end
  end

`ifdef ADBG_TAP_USER_REG_EN
  logic [31:0] user_shift;

  // User data register: captures the current value, updates the output on UPDATE_DR
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      user_shift <= '0;
      user_reg_o <= '0;
    end else if (user_sel) begin
      if (state == CAPTURE_DR)
        user_shift <= user_reg_o;
      else if (state == SHIFT_DR)
        user_shift <= {tdi_i, user_shift[31:1]};
      else if (state == UPDATE_DR)
        user_reg_o <= user_shift;
    end
  end
`endif

  // TDO source selection from the current state and latched instruction
  always_comb begin
    tdo_mux = 1'b0;
    if (state == SHIFT_IR) begin
      tdo_mux = ir_shift[0];
    end else if (state == SHIFT_DR) begin
      if (debug_sel)
        tdo_mux = dbg_tdo_i;
      else if (idcode_sel)
        tdo_mux = idcode_shift[0];
`ifdef ADBG_TAP_USER_REG_EN
      else if (user_sel)
        tdo_mux = user_shift[0];
`endif
      else
        tdo_mux = bypass_reg;
    end
  end

  // TDO and its enable are launched on falling TCK
  always_ff @(negedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      tdo_o    <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      tdo_o    <= tdo_mux;
      tdo_oe_o <= (state == SHIFT_IR) || (state == SHIFT_DR);
    end
  end

endmodule

// File: tb/tb_adbg_jtag_tap.sv
// tb_adbg_jtag_tap: self-checking bench for adbg_jtag_tap.
// A table-driven TAP model tracks state, IR and the selected DR; every TCK
// cycle checks TDO/OE and the strobes, plus directed value checks.
module tb_adbg_jtag_tap;

  localparam logic [31:0] IDCODE_V = 32'h249511C3;
  localparam logic [3:0]  OP_IDCODE = 4'h2;
  localparam logic [3:0]  OP_DEBUG  = 4'h8;
  localparam logic [3:0]  OP_USER   = 4'h9;

  // model state indices in 1149.1 order
  localparam int S_TLR = 0, S_CDR = 3, S_SDR = 4, S_PDR = 6, S_UDR = 8;
  localparam int S_CIR = 10, S_SIR = 11, S_UIR = 15;

  logic tck = 1'b0;
  logic trstn_i = 1'b0;
  logic tms_i = 1'b1;
  logic tdi_i = 1'b0;
  logic dbg_tdo_i = 1'b0;
  logic tdo_o, tdo_oe_o, test_logic_reset_o, shift_dr_o, pause_dr_o;
  logic update_dr_o, capture_dr_o, debug_select_o;
`ifdef ADBG_TAP_USER_REG_EN
  logic [31:0] user_reg_o;
`endif

  adbg_jtag_tap dut (
    .tck_i              (tck),
    .trstn_i            (trstn_i),
    .tms_i              (tms_i),
    .tdi_i              (tdi_i),
    .tdo_o              (tdo_o),
    .tdo_oe_o           (tdo_oe_o),
    .test_logic_reset_o (test_logic_reset_o),
    .shift_dr_o         (shift_dr_o),
    .pause_dr_o         (pause_dr_o),
    .update_dr_o        (update_dr_o),
    .capture_dr_o       (capture_dr_o),
    .debug_select_o     (debug_select_o),
    .dbg_tdo_i          (dbg_tdo_i)
`ifdef ADBG_TAP_USER_REG_EN
    ,
    .user_reg_o         (user_reg_o)
`endif
  );

  always #5 tck = ~tck;

  int tests = 0;
  int fails = 0;
  int nxt0 [16];
  int nxt1 [16];

  int          mst;
  logic [3:0]  mir, mirsh;
  logic [31:0] mdr, muser;
  int          mlen;
  logic        exp_tdo, exp_oe, last_tdo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mst = S_TLR; mir = OP_IDCODE; mirsh = '0; mdr = '0; mlen = 1; muser = '0;
    exp_tdo = 1'b0; exp_oe = 1'b0;
  endtask

  // 0 idcode, 1 debug, 2 user, 3 bypass
  function automatic int dr_kind(input logic [3:0] ir);
    if (ir == OP_IDCODE) return 0;
    if (ir == OP_DEBUG) return 1;
`ifdef ADBG_TAP_USER_REG_EN
    if (ir == OP_USER) return 2;
`endif
    return 3;
  endfunction

  task automatic model_clk(input logic tms, input logic tdi);
    int k;
    k = dr_kind(mir);
    if (mst == S_TLR) mir = OP_IDCODE;
    if (mst == S_CIR) mirsh = 4'b0001;
    if (mst == S_SIR) mirsh = {tdi, mirsh[3:1]};
    if (mst == S_UIR) mir = mirsh;
    if (mst == S_CDR) begin
      mlen = (k == 3) ? 1 : 32;
      mdr  = (k == 0) ? IDCODE_V : (k == 2) ? muser : 32'h0;
    end
    if (mst == S_SDR) mdr = (mdr >> 1) | (32'(tdi) << (mlen - 1));
    if (mst == S_UDR && k == 2) muser = mdr;
    mst = tms ? nxt1[mst] : nxt0[mst];
  endtask

  // one TCK cycle: check falling-edge outputs, drive, then check strobes
  task automatic step(input logic tms, input logic tdi, input logic dbg);
    @(negedge tck); #1;
    chk("tdo", 32'(tdo_o), 32'(exp_tdo));
    chk("tdo_oe", 32'(tdo_oe_o), 32'(exp_oe));
    last_tdo = tdo_o;
    tms_i = tms; tdi_i = tdi; dbg_tdo_i = dbg;
    @(posedge tck);
    model_clk(tms, tdi);
    #1;
    chk("strobes", 32'({test_logic_reset_o, shift_dr_o, pause_dr_o, update_dr_o,
                        capture_dr_o, debug_select_o}),
        32'({mst == S_TLR, mst == S_SDR, mst == S_PDR, mst == S_UDR,
             mst == S_CDR, mir == OP_DEBUG}));
`ifdef ADBG_TAP_USER_REG_EN
    chk("user_reg", user_reg_o, muser);
`endif
    exp_oe  = (mst == S_SIR) || (mst == S_SDR);
    exp_tdo = 1'b0;
    if (mst == S_SIR) exp_tdo = mirsh[0];
    if (mst == S_SDR) exp_tdo = (dr_kind(mir) == 1) ? dbg : mdr[0];
  endtask

  task automatic rnd_step(input logic tms);
    step(tms, 1'($urandom), 1'($urandom));
  endtask

  // from any state: reset via TMS, land in RUN_TEST_IDLE, load IR
  task automatic load_ir(input logic [3:0] val, output logic [3:0] cap);
    for (int i = 0; i < 5; i++) rnd_step(1'b1);
    rnd_step(1'b0); rnd_step(1'b1); rnd_step(1'b1); rnd_step(1'b0); rnd_step(1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, val[i], 1'($urandom));
      cap[i] = last_tdo;
    end
    rnd_step(1'b1); rnd_step(1'b0);
  endtask

  // from RUN_TEST_IDLE: capture, shift n bits, update, back to idle
  task automatic shift_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    rnd_step(1'b1); rnd_step(1'b0); rnd_step(1'b0);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], 1'($urandom));
      dout[i] = last_tdo;
    end
    rnd_step(1'b1); rnd_step(1'b0);
  endtask

  task automatic apply_reset();
    tms_i = 1'b1;
    #2 trstn_i = 1'b0;
    model_reset();
    #1;
    chk("rst_tlr", 32'(test_logic_reset_o), 32'h1);
    chk("rst_strobes", 32'({shift_dr_o, pause_dr_o, update_dr_o, capture_dr_o}), 32'h0);
    chk("rst_tdo", 32'({tdo_o, tdo_oe_o}), 32'h0);
    chk("rst_dbgsel", 32'(debug_select_o), 32'h0);
    @(negedge tck); #2 trstn_i = 1'b1;
  endtask

  logic [3:0]  ircap;
  logic [63:0] dout;

  initial begin
    nxt0 = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    nxt1 = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    model_reset();
    #12 trstn_i = 1'b1;

    // IDCODE read straight out of reset
    rnd_step(1'b0);
    shift_dr(32, {32'h0, $urandom}, dout);
    chk("idcode", dout[31:0], IDCODE_V);

    // five TMS=1 from idle reach reset, further ones hold it
    for (int i = 0; i < 5; i++) rnd_step(1'b1);
    chk("tms_reset", 32'(test_logic_reset_o), 32'h1);
    rnd_step(1'b1); rnd_step(1'b1);
    chk("tms_hold", 32'(test_logic_reset_o), 32'h1);

    // DEBUG instruction: IR capture pattern, select, dbg_tdo passthrough
    load_ir(OP_DEBUG, ircap);
    chk("ir_capture", 32'(ircap), 32'h1);
    chk("debug_sel", 32'(debug_select_o), 32'h1);
    shift_dr(16, {$urandom, $urandom}, dout);
    rnd_step(1'b1); rnd_step(1'b0); rnd_step(1'b0);
    rnd_step(1'b0); rnd_step(1'b1); rnd_step(1'b0); rnd_step(1'b0);
    rnd_step(1'b1); rnd_step(1'b0); rnd_step(1'b1); rnd_step(1'b1); rnd_step(1'b0);

    // BYPASS and an unlisted opcode: 0 then the data one clock late
    load_ir(4'hF, ircap);
    shift_dr(9, {55'h0, 1'($urandom), 8'hA5}, dout);
    chk("bypass_F", dout[8:0], 32'h14A);
    load_ir(4'h3, ircap);
    shift_dr(9, {55'h0, 1'($urandom), 8'hA5}, dout);
    chk("bypass_3", dout[8:0], 32'h14A);

`ifdef ADBG_TAP_USER_REG_EN
    load_ir(OP_USER, ircap);
    shift_dr(32, {32'h0, 32'hDEADBEEF}, dout);
    chk("user_update", user_reg_o, 32'hDEADBEEF);
    shift_dr(32, {32'h0, $urandom}, dout);
    chk("user_readback", dout[31:0], 32'hDEADBEEF);
`endif

    // reset asserted mid SHIFT_DR aborts without an update
    load_ir(OP_DEBUG, ircap);
    rnd_step(1'b1); rnd_step(1'b0); rnd_step(1'b0); rnd_step(1'b0); rnd_step(1'b0);
    chk("in_shift_dr", 32'(shift_dr_o), 32'h1);
    apply_reset();
    rnd_step(1'b1);

    // random walk through the whole FSM with random IR/DR traffic
    for (int i = 0; i < 600; i++) rnd_step(($urandom % 5) < 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
